tower_sprite_mem: RTL and testbench



---
 rtl/tower_sprite_mem.sv | 113 +++++++++++
 tb/tb_tower_sprite_mem.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tower_sprite_mem.sv
// ---------------------------------------------------------------------------
// tower_sprite_mem
//
// Sprite memory for the 20x20 tower tile on the VGA drawing path. A pixel
// coordinate (x, y) inside the tile is turned into a linear word address
// (y*20 + x). The 9-bit RRRGGGBBB colour stored at that address appears on
// q one clock later.
//
// Build option:
//   TOWER_RAM_WRITE_EN  When defined, the data/wren write port is active
//                       and the image can be replaced at run time.
//                       When undefined, the block is a ROM. data and wren
//                       are then ignored, but the ports are still present.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset (clears q/q_valid only)
//   x            in   [4:0] column within tile, 0..19 valid
//   y            in   [4:0] row within tile, 0..19 valid
//   data         in   [8:0] write colour
//   wren         in   write enable
//   mem_address  out  [8:0] combinational linear address
//   q            out  [8:0] registered read colour
//   q_valid      out  registered: the coordinate sampled with q was in range
// ---------------------------------------------------------------------------
module tower_sprite_mem #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned HEIGHT = 20,
    parameter int unsigned DEPTH  = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [8:0] data,
    input  logic       wren,
    output logic [8:0] mem_address,
    output logic [8:0] q,
    output logic       q_valid
);

    localparam logic [4:0] WidthL  = 5'(WIDTH);
    localparam logic [4:0] HeightL = 5'(HEIGHT);

    logic [8:0] y_ext;
    logic [8:0] x_ext;
    logic       in_range;
    logic [8:0] rd_word;

    logic [8:0] q_d, q_q;
    logic       q_valid_d, q_valid_q;

    // y*20 as (y*16 + y*4). Out-of-range inputs wrap modulo 512.
    always_comb begin
        y_ext       = {4'b0000, y};
        x_ext       = {4'b0000, x};
        mem_address = (y_ext << 4) + (y_ext << 2) + x_ext;
        in_range    = (x < WidthL) && (y < HeightL);
    end

`ifdef TOWER_RAM_WRITE_EN
    // Each word is stored XORed with its own address. Because of this, an
    // all-zero array at power-up reads back as word[a] = a, which is the
    // default identity image. Reset leaves the array contents untouched.
    logic [8:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset && wren && in_range) begin
            mem_q[mem_address] <= data ^ mem_address;
        end
    end

    // The read uses the pre-edge array value. A read and a write to the same
    // address in the same cycle therefore returns the old word (read-first).
    always_comb begin
        rd_word = 9'h000;
        if (in_range) begin
            rd_word = mem_q[mem_address] ^ mem_address;
        end
    end
`else
    // ROM image: word[a] = a. A read therefore returns the address itself.
    logic unused_wr_port;
    assign unused_wr_port = ^{data, wren};

    always_comb begin
        rd_word = mem_address;
    end
`endif

    always_comb begin
        q_d       = 9'h000;
        q_valid_d = 1'b0;
        if (in_range) begin
            q_d       = rd_word;
            q_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q       <= 9'h000;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_tower_sprite_mem.sv
// Scoreboard bench for tower_sprite_mem: the driver pushes expected {q_valid, q}
// for each coordinate it applies, and a monitor pops and compares one entry
// after every rising edge.
module tb_tower_sprite_mem;

    logic       clk;
    logic       reset;
    logic [4:0] x;
    logic [4:0] y;
    logic [8:0] data;
    logic       wren;
    logic [8:0] mem_address;
    logic [8:0] q;
    logic       q_valid;

    int checks;
    int errors;
    logic [9:0] sb[$];

    tower_sprite_mem dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .data        (data),
        .wren        (wren),
        .mem_address (mem_address),
        .q           (q),
        .q_valid     (q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Applies one coordinate at the falling edge and checks the combinational
    // address. It then queues the registered result expected after the next
    // rising edge.
    task automatic drive(input logic [4:0] xi, input logic [4:0] yi, input logic we,
                         input logic [8:0] di, input logic [8:0] exp_addr,
                         input logic [8:0] exp_q, input logic exp_v);
        @(negedge clk);
        x = xi; y = yi; wren = we; data = di;
        #1;
        check($sformatf("addr(%0d,%0d)", xi, yi), int'(mem_address), int'(exp_addr));
        sb.push_back({exp_v, exp_q});
    endtask

    // Monitor: every rising edge, compare the outputs against the oldest queued
    // expectation.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("q", int'(q), int'(e[8:0]));
                check("q_valid", int'(q_valid), int'(e[9]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        checks = 0; errors = 0;
        reset = 1'b1; x = 5'd5; y = 5'd5; data = 9'h000; wren = 1'b0;
        #1;
        check("por_q", int'(q), 0);
        check("por_q_valid", int'(q_valid), 0);
        repeat (2) @(posedge clk);

        // Reset release: the first edge after release samples (5,5), giving 105.
        @(negedge clk); reset = 1'b0;
        sb.push_back({1'b1, 9'h069});
        @(posedge clk);

        // Asynchronous reset clears the outputs immediately and holds them.
        @(negedge clk);
        x = 5'd5; y = 5'd5;
        reset = 1'b1;
        #1;
        check("async_rst_q", int'(q), 0);
        check("async_rst_q_valid", int'(q_valid), 0);
        @(posedge clk); #1;
        check("held_rst_q", int'(q), 0);
        check("held_rst_q_valid", int'(q_valid), 0);
        @(negedge clk); reset = 1'b0;
        sb.push_back({1'b1, 9'h069});
        @(posedge clk);

        // Address corners.
        drive(5'd0,  5'd0,  1'b0, 9'h000, 9'd0,   9'd0,   1'b1);
        drive(5'd19, 5'd0,  1'b0, 9'h000, 9'd19,  9'd19,  1'b1);
        drive(5'd0,  5'd1,  1'b0, 9'h000, 9'd20,  9'd20,  1'b1);
        drive(5'd19, 5'd19, 1'b0, 9'h000, 9'd399, 9'h18F, 1'b1);

        // Full raster sweep.
        for (int yy = 0; yy < 20; yy++) begin
            for (int xx = 0; xx < 20; xx++) begin
                drive(5'(xx), 5'(yy), 1'b0, 9'h000, 9'(yy * 20 + xx), 9'(yy * 20 + xx), 1'b1);
            end
        end

        // Out of range, then recovery with an in-range coordinate.
        drive(5'd20, 5'd0,  1'b0, 9'h000, 9'd20,  9'h000, 1'b0);
        drive(5'd3,  5'd25, 1'b0, 9'h000, 9'd503, 9'h000, 1'b0);
        drive(5'd31, 5'd31, 1'b1, 9'h1FF, 9'd139, 9'h000, 1'b0);
        drive(5'd4,  5'd2,  1'b0, 9'h000, 9'd44,  9'd44,  1'b1);

        // Read-during-write at (7,3): the old word is returned that cycle.
        drive(5'd7, 5'd3, 1'b1, 9'h1C7, 9'd67, 9'h043, 1'b1);
`ifdef TOWER_RAM_WRITE_EN
        drive(5'd7, 5'd3, 1'b0, 9'h000, 9'd67, 9'h1C7, 1'b1);
`else
        drive(5'd7, 5'd3, 1'b0, 9'h000, 9'd67, 9'h043, 1'b1);
`endif
        // The out-of-range write above must not have touched word 139.
        drive(5'd19, 5'd6, 1'b0, 9'h000, 9'd139, 9'd139, 1'b1);

        // A write attempted while reset is high is suppressed.
        @(negedge clk);
        reset = 1'b1; x = 5'd1; y = 5'd1; wren = 1'b1; data = 9'h0FF;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; wren = 1'b0;
        drive(5'd1, 5'd1, 1'b0, 9'h000, 9'd21, 9'h015, 1'b1);

        // Drain the scoreboard within a bounded number of cycles.
        waited = 0;
        while (sb.size() != 0 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
